gat_feat_streamer: RTL

Read-side drain engine for the new-feature BRAM of the GAT accelerator. After the core raises `gat_ready`, a `start` request makes the block walk every word of the new-feature memory in address order and present it as an AXI4-Stream master. The block drives the BRAM byte-address read port (`feat_bram_addrb` / `feat_bram_dout`) and absorbs BRAM read latency and downstream backpressure with a small credit-controlled FIFO. Results therefore reach the PS/DMA without per-word register-bank reads.

---
 rtl/gat_feat_streamer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/gat_feat_streamer.sv
// gat_feat_streamer
// -----------------
// Drains the GAT new-feature BRAM as an AXI4-Stream master. Once the core has
// raised gat_ready, a start request walks every word of the memory in address
// order. BRAM read latency and downstream backpressure are absorbed by a small
// FIFO. Reads are only issued while the FIFO has room for every word still
// in flight (credit control).
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   gat_ready         : core finished, BRAM contents are final
//   start             : drain request (level or pulse), accepted only in IDLE
//   busy              : high from start accept until done
//   done              : one-cycle pulse after the last beat is handshaken
//   feat_bram_addrb   : BRAM byte address (word index << 2)
//   feat_bram_dout    : BRAM read data, valid BRAM_LATENCY cycles after addrb
//   m_axis_tdata      : stream data (FIFO head, 0 when FIFO empty)
//   m_axis_tvalid     : stream valid (FIFO not empty)
//   m_axis_tready     : stream ready
//   m_axis_tlast      : marks word NEW_FEATURE_DEPTH-1
//
// Handshake: a beat transfers on a rising edge where m_axis_tvalid and
// m_axis_tready are both high. While tvalid is high and tready is low,
// tdata and tlast hold and tvalid stays high.
module gat_feat_streamer #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int BRAM_LATENCY       = 2,
  parameter int FIFO_DEPTH         = BRAM_LATENCY + 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            gat_ready,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]    feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]    m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);

  // Index/beat counters can hold NEW_FEATURE_DEPTH itself, so they never wrap.
  localparam int IDX_W = ($clog2(NEW_FEATURE_DEPTH + 1) < 1) ? 1 : $clog2(NEW_FEATURE_DEPTH + 1);
  localparam int PTR_W = ($clog2(FIFO_DEPTH) < 1) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  // Credit sum (inflight + fifo_count) can reach up to 2*FIFO_DEPTH.
  localparam int CRD_W = CNT_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEW_FEATURE_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                rd_idx;
  logic [IDX_W-1:0]                beat_cnt;
  logic [NEW_FEATURE_ADDR_W+1:0]   addr_q;
  logic [BRAM_LATENCY-1:0]         pipe;
  logic [NEW_FEATURE_WIDTH-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]                wr_ptr, rd_ptr;
  logic [CNT_W-1:0]                fifo_count;

  logic                            accept;
  logic                            issue;
  logic                            push;
  logic                            pop;
  logic                            fifo_empty;
  logic [CRD_W-1:0]                inflight;
  logic [IDX_W+1:0]                addr_full;

  // Words requested from the BRAM but not yet in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) begin
      inflight = inflight + CRD_W'(pipe[i]);
    end
  end

  assign accept     = (state_q == IDLE) && start && gat_ready;
  // Both credit terms are registered; a pop this cycle is not credited.
  assign issue      = (state_q == READ) && ((inflight + CRD_W'(fifo_count)) < CRD_MAX);
  assign push       = pipe[BRAM_LATENCY-1];
  assign fifo_empty = (fifo_count == '0);
  assign pop        = m_axis_tvalid && m_axis_tready;

  // The address is presented in the issue cycle itself and held otherwise.
  assign addr_full       = {rd_idx, 2'b00};
  assign feat_bram_addrb = issue ? addr_full[NEW_FEATURE_ADDR_W+1:0] : addr_q;

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid && (beat_cnt == LAST_IDX);

  assign busy = (state_q == READ) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    if (issue && (rd_idx == LAST_IDX)) state_d = DRAIN;
      DRAIN:   if (pop && m_axis_tlast) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_idx     <= '0;
      beat_cnt   <= '0;
      addr_q     <= '0;
      pipe       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= feat_bram_addrb;

      if (accept) begin
        rd_idx <= '0;
      end else if (issue) begin
        rd_idx <= rd_idx + 1'b1;
      end

      if (accept) begin
        beat_cnt <= '0;
      end else if (pop) begin
        beat_cnt <= beat_cnt + 1'b1;
      end

      // Valid shift register tracking outstanding BRAM reads.
      if (accept) begin
        pipe <= '0;
      end else begin
        pipe[0] <= issue;
        for (int i = 1; i < BRAM_LATENCY; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end

      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage needs no reset: tdata is forced to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= feat_bram_dout;
  end

  // Credit control must make a push into a full FIFO impossible.
  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_count == CNT_FULL)));

endmodule
